gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
- Self-checking stimulus sequencer for a 2-input gate cell, for example the cmosxnor cell with inputs a, b and output f53.
- On start it drives the four input vectors 00, 01, 10, 11 in order. Each vector is held for a programmable number of clock cycles.
- At the end of each hold window it samples the gate output and compares it against a parameterised truth table.
- It accumulates a mismatch count and a per-vector fail map, then reports done/pass. Used in bring-up benches and on-chip self-test of gate cells.

Parameters:
- HOLD, default 5: cycles each vector is held; legal range 1..255.
- EXPECT, default 4'b1001: expected output indexed by {a,b}; bit k is the expected value for vector k. The default is the XNOR truth table.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- abort  input  1  cancel the sweep in progress
- f53  input  1  output of the gate under test
- a  output  1  gate input a, registered
- b  output  1  gate input b, registered
- busy  output  1  sweep in progress
- done  output  1  sweep completed; held until the next start or reset
- pass  output  1  done and zero mismatches
- err_cnt  output  3  number of mismatched vectors, 0..4
- fail_vec  output  4  bit k set if vector k mismatched

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; a=b=0; busy=done=pass=0; err_cnt=0; fail_vec=0; hold counter=0; vector index=0.
- States: IDLE, DRIVE, DONE.
- IDLE: if start=1 at edge E0, go to DRIVE. After E0:
  - busy=1, {a,b}=00
  - done=pass=0, err_cnt=0, fail_vec=0
  - vector index=0, hold counter=0
- DRIVE, hold counter below HOLD-1: increment the counter each cycle.
- DRIVE, hold counter equals HOLD-1 (the last cycle of vector k's window):
  - Sample f53 at that edge. On f53 != EXPECT[k], increment err_cnt and set fail_vec[k].
  - If k<3: apply vector k+1 to {a,b} at the same edge and clear the counter.
  - If k=3: go to DONE; a=b=0, busy=0, done=1, pass = (final err_cnt==0). The final err_cnt includes a mismatch on vector 3.
- Timing: vector k is applied at edge E0+k*HOLD and sampled at edge E0+(k+1)*HOLD. done rises after edge E0+4*HOLD (edge 20 for HOLD=5).
- HOLD=1: one cycle per vector. f53 is sampled one edge after the vector is applied, so the combinational gate path must settle within one clock.
- DONE: outputs hold. start=1 behaves exactly as start in IDLE, including clearing the results.
- start while busy: ignored.
- abort=1 in DRIVE, takes priority over the sample on the same edge:
  - go to IDLE; a=b=0, busy=0, done=0, pass=0
  - err_cnt and fail_vec keep their partial values
- abort in IDLE or DONE: no effect.
- start and abort together in IDLE or DONE: start wins.
- rst asserted mid-sweep: immediate return to reset values, no completion flag.
- err_cnt saturation is not needed: at most 4 increments.

Decomposition:
- Package gate_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, DONE)
  - NUM_VEC=4
  - truth-table constants XNOR_TT=4'b1001, XOR_TT=4'b0110, NAND_TT=4'b0111
- One sub-module, sweep_hold_timer: an 8-bit counter with clear/enable inputs and a terminal-count output at HOLD-1.

Test Plan:
- Correct XNOR model, HOLD=5, start pulse at E0 -> {a,b}=00,01,10,11 at E0, E0+5, E0+10, E0+15; done=1 and pass=1 after E0+20; err_cnt=0, fail_vec=0000.
- Model forced to output constant 1 -> err_cnt=2, fail_vec=0110, pass=0, done=1.
- XOR model with default EXPECT -> err_cnt=4, fail_vec=1111, pass=0.
- abort asserted at E0+7 -> busy=0, done=0 after E0+7, a=b=0, state IDLE; a new start then completes normally at E0'+20.
- rst pulsed at E0+12 -> all outputs 0 immediately, asynchronously; start pulsed 3 cycles after rst releases -> full sweep completes.
- HOLD=1 with correct model -> done after E0+4, pass=1; a second start while in DONE clears the results and reruns.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  localparam int unsigned NUM_VEC = 4;

  // Truth tables indexed by {a,b}: bit k is the expected output for vector k.
  localparam logic [3:0] XNOR_TT = 4'b1001;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;

  // Expected gate output for vector idx under truth table tt.
  function automatic logic tt_bit(input logic [3:0] tt, input logic [1:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold-window counter: counts 0..HOLD-1 and flags the last cycle of a window.
module sweep_hold_timer #(
  parameter int unsigned HOLD = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] LAST = 8'(HOLD - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives the four input vectors of a 2-input gate, samples its output at the
// end of each hold window and accumulates a mismatch count and fail map.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned HOLD   = 5,
  parameter logic [3:0]  EXPECT = XNOR_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       f53,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  sweep_state_e state_q;
  logic       a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0] err_cnt_q;
  logic [3:0] fail_vec_q;
  logic [1:0] idx_q;

  logic       tc_s;
  logic       timer_clr_s;
  logic       timer_en_s;
  logic       mismatch_s;
  logic [2:0] err_next_s;

  sweep_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (timer_clr_s),
    .en_i  (timer_en_s),
    .tc_o  (tc_s)
  );

  assign mismatch_s = (f53 != tt_bit(EXPECT, idx_q));
  assign err_next_s = err_cnt_q + 3'(mismatch_s);

  // Timer control: restart on sweep start, window end or abort; count otherwise.
  always_comb begin
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        timer_clr_s = start;
      end
      DRIVE: begin
        if (abort || tc_s) begin
          timer_clr_s = 1'b1;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      default: begin
        timer_clr_s = 1'b1;
      end
    endcase
  end

  // Sweep FSM with registered outputs; abort outranks the window-end sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 3'd0;
      fail_vec_q <= 4'd0;
      idx_q      <= 2'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= DRIVE;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 3'd0;
            fail_vec_q <= 4'd0;
            idx_q      <= 2'd0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            idx_q   <= 2'd0;
          end else if (tc_s) begin
            err_cnt_q <= err_next_s;
            if (mismatch_s) begin
              fail_vec_q[idx_q] <= 1'b1;
            end
            if (idx_q == 2'(NUM_VEC - 1)) begin
              state_q <= DONE;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_next_s == 3'd0);
              idx_q   <= 2'd0;
            end else begin
              idx_q      <= idx_q + 2'd1;
              {a_q, b_q} <= idx_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          a_q     <= 1'b0;
          b_q     <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          idx_q   <= 2'd0;
        end
      endcase
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: a HOLD=5 instance and a HOLD=1 instance,
// each fed by a behavioural gate model selectable per test.
module tb_gate_sweep_ctrl;

  localparam int M_XNOR = 0;
  localparam int M_ONE  = 1;
  localparam int M_XOR  = 2;
  localparam int M_NAND = 3;
  localparam int M_ZERO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  int mode5 = M_XNOR;
  int mode1 = M_XNOR;

  logic       f5, a5, b5, busy5, done5, pass5;
  logic [2:0] err5;
  logic [3:0] fail5;
  logic       f1, a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fail1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic gate(input int m, input logic ia, input logic ib);
    case (m)
      M_XNOR:  return ~(ia ^ ib);
      M_ONE:   return 1'b1;
      M_XOR:   return ia ^ ib;
      M_NAND:  return ~(ia & ib);
      default: return 1'b0;
    endcase
  endfunction

  assign f5 = gate(mode5, a5, b5);
  assign f1 = gate(mode1, a1, b1);

  gate_sweep_ctrl #(.HOLD(5), .EXPECT(4'b1001)) dut5 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f53(f5),
    .a(a5), .b(b5), .busy(busy5), .done(done5), .pass(pass5),
    .err_cnt(err5), .fail_vec(fail5)
  );

  gate_sweep_ctrl #(.HOLD(1), .EXPECT(4'b1001)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f53(f1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fail1)
  );

  typedef struct {
    int         mode;
    logic       mid_start;
    logic       start_abort;
    logic [2:0] exp_err;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } sweep_vec_t;

  sweep_vec_t vecs [5];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full HOLD=5 sweep: checks vector timing, done edge and final results.
  task automatic run5(input sweep_vec_t v);
    mode5 = v.mode;
    start = 1'b1;
    abort = v.start_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_busy", {7'd0, busy5}, 8'd1);
    chk("start_ab", {6'd0, a5, b5}, 8'd0);
    chk("start_clr", {1'b0, err5, fail5}, 8'd0);
    chk("start_done", {6'd0, done5, pass5}, 8'd0);
    for (int c = 1; c <= 20; c++) begin
      start = v.mid_start && (c == 3);
      tick();
      start = 1'b0;
      if ((c % 5) == 0 && c < 20) chk("vec_ab", {6'd0, a5, b5}, 8'(c / 5));
      if (c == 19) chk("pre_done", {6'd0, busy5, done5}, 8'b10);
    end
    chk("end_flags", {5'd0, busy5, done5, pass5}, {5'd0, 1'b0, 1'b1, v.exp_pass});
    chk("end_ab", {6'd0, a5, b5}, 8'd0);
    chk("end_err", {5'd0, err5}, {5'd0, v.exp_err});
    chk("end_fail", {4'd0, fail5}, {4'd0, v.exp_fail});
  endtask

  initial begin
    vecs[0] = '{M_XNOR, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1};
    vecs[1] = '{M_ONE,  1'b1, 1'b0, 3'd2, 4'b0110, 1'b0};
    vecs[2] = '{M_XOR,  1'b0, 1'b1, 3'd4, 4'b1111, 1'b0};
    vecs[3] = '{M_NAND, 1'b0, 1'b0, 3'd3, 4'b1110, 1'b0};
    vecs[4] = '{M_ZERO, 1'b1, 1'b1, 3'd2, 4'b1001, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_outs", {a5, b5, busy5, done5, pass5, err5}, 8'd0);
    chk("rst_fail", {4'd0, fail5}, 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {7'd0, busy5}, 8'd0);

    // Table of full sweeps (back-to-back restarts from DONE included)
    foreach (vecs[i]) run5(vecs[i]);

    // Abort mid-sweep keeps partial results
    mode5 = M_XOR;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_flags", {5'd0, busy5, done5, pass5}, 8'd0);
    chk("abort_ab", {6'd0, a5, b5}, 8'd0);
    chk("abort_err", {5'd0, err5}, 8'd1);
    chk("abort_fail", {4'd0, fail5}, 8'b0001);
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    chk("abort_idle", {busy5, done5, 3'd0, err5}, 8'd1);
    run5(vecs[0]);

    // Asynchronous reset mid-sweep
    mode5 = M_XOR;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) tick();
    chk("pre_rst_ab", {6'd0, a5, b5}, 8'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {a5, b5, busy5, done5, pass5, err5}, 8'd0);
    chk("async_rst_fail", {4'd0, fail5}, 8'd0);
    #1 rst = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    chk("post_rst_idle", {6'd0, busy5, done5}, 8'd0);
    run5(vecs[0]);

    // HOLD=1: XOR run, then restart from DONE with a correct model
    tick();
    mode1 = M_XOR;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("h1_ab0", {5'd0, busy1, a1, b1}, 8'b100);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 4) chk("h1_ab", {6'd0, a1, b1}, 8'(c));
    end
    chk("h1_xor_done", {6'd0, done1, pass1}, 8'b10);
    chk("h1_xor_err", {1'b0, err1, fail1}, {1'b0, 3'd4, 4'b1111});
    mode1 = M_XNOR;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("h1_restart", {5'd0, busy1, done1, pass1}, 8'b100);
    chk("h1_restart_clr", {1'b0, err1, fail1}, 8'd0);
    for (int c = 1; c <= 3; c++) tick();
    chk("h1_pre_done", {6'd0, busy1, done1}, 8'b10);
    tick();
    chk("h1_done", {5'd0, busy1, done1, pass1}, 8'b011);
    chk("h1_res", {1'b0, err1, fail1}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
